multi_pulse_gen: RTL
====================

Name: multi_pulse_gen

Overview:
Parametrised, multi-channel successor to the single-channel rising-edge pulse generator. Each channel optionally synchronises an asynchronous level input, detects rising, falling or both edges, and emits a registered pulse whose length is programmable. Channels can optionally be retriggered while a pulse is active. Sits between clock-domain-crossing level signals (enables, toggles, requests) and single-domain logic that needs one-shot strobes.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel input (0..3); 0 = input used raw
LEN_W, 4, width of pulse-length field and per-channel down-counter (>=1)

Ports:
i_CLK  input  1  single clock for all logic
i_RST  input  1  asynchronous active-low reset
i_level  input  CH  per-channel level inputs; bit n = channel n
i_edge_mode  input  2  shared detect mode: 00 rise, 01 fall, 10 both, 11 detection disabled
i_pulse_len  input  LEN_W  pulse length in cycles; 0 treated as 1
i_retrig  input  1  1 = edge during active pulse reloads length; 0 = ignored
o_pulse  output  CH  per-channel registered pulse
o_overrun  output  CH  1-cycle registered flag: edge ignored (active, i_retrig=0)
o_any  output  1  OR of o_pulse (combinational from registers only)

Behaviour:
- Reset (asynchronous, i_RST=0): sync flops, prev-level regs, counters, o_pulse, o_overrun all 0; every channel IDLE; o_any=0. Reset mid-pulse terminates the pulse immediately.
- Per channel: s = i_level[n] after SYNC_STAGES flops (raw if 0); prev <= s every cycle.
- Edge detect (combinational): rise = s & ~prev; fall = ~s & prev; edge = rise (00), fall (01), rise|fall (10), 0 (11).
- L_eff = (i_pulse_len==0) ? 1 : i_pulse_len; sampled only at the trigger edge. Later changes to i_pulse_len or i_edge_mode do not alter an active pulse.
- FSM per channel, states IDLE / ACTIVE:
  - IDLE, edge=1: -> ACTIVE, cnt <= L_eff-1, o_pulse <= 1.
  - IDLE, edge=0: stay, o_pulse <= 0.
  - ACTIVE, edge=1 and i_retrig=1: cnt <= L_eff-1, stay ACTIVE, o_pulse stays 1 (pulse extended; no gap).
  - ACTIVE, edge=1 and i_retrig=0: edge ignored, o_overrun <= 1 for one cycle; counting continues.
  - ACTIVE, otherwise: if cnt!=0, cnt <= cnt-1; if cnt==0, -> IDLE, o_pulse <= 0.
  - ACTIVE with cnt==0 and edge with i_retrig=0: -> IDLE (edge ignored, o_overrun=1); that edge never starts a new pulse.
- Pulse width: exactly L_eff cycles high per non-retriggered trigger; max 2^LEN_W-1.
- Latency: input change first sampled at clock edge k -> o_pulse high from edge k+SYNC_STAGES onward (SYNC_STAGES=0: from edge k itself).
- Level already high at reset release yields one rising-edge pulse (legacy-compatible).
- Mode 11: no new triggers; active pulses run to completion.
- Channels fully independent; simultaneous edges on several channels each trigger.
- o_overrun otherwise 0; cleared the cycle after assertion.

Test Plan:
- CH=4, SYNC=2, mode 00, len=3, retrig=0: ch0 low->high -> o_pulse[0] high exactly 3 cycles starting 2 edges after first sampling edge; other bits 0; o_any mirrors.
- mode 01, len=0: ch2 high->low -> o_pulse[2] high 1 cycle; rising edge on ch2 -> no pulse.
- mode 10, len=5, retrig=1: ch1 toggles at t and t+3 -> o_pulse[1] high continuously 8 cycles, o_overrun[1]=0.
- Same with retrig=0 -> o_pulse[1] high 5 cycles, o_overrun[1]=1 exactly one cycle, after second toggle's sync latency.
- len=15, trigger ch3, change i_pulse_len to 2 and mode to 11 mid-pulse -> pulse still 15 cycles; subsequent edges produce nothing.
- Trigger all 4 channels same cycle, assert i_RST low mid-pulse -> all o_pulse/o_overrun 0 immediately, before next clock; after release with i_level=4'hF, mode 00 -> one pulse per channel.

Source files
------------

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen
//   Multi-channel one-shot pulse generator. Each channel takes an
//   asynchronous level input through an optional synchroniser and
//   detects rising, falling or both edges. On a detected edge it emits
//   a registered pulse of programmable length. A channel can be
//   retriggered while its pulse is active. If it is not retriggered,
//   the edge is reported on o_overrun.
//
// Parameters
//   CH          number of independent channels (>=1)
//   SYNC_STAGES synchroniser flops per channel (0..3); 0 = raw input
//   LEN_W       width of the pulse-length field and per-channel counter
//
// Ports
//   i_CLK        clock for all logic
//   i_RST        asynchronous active-low reset
//   i_level      per-channel level inputs (bit n = channel n)
//   i_edge_mode  00 rise, 01 fall, 10 both, 11 detection disabled
//   i_pulse_len  pulse length in cycles (0 behaves as 1)
//   i_retrig     1 = edge during an active pulse reloads the length
//   o_pulse      per-channel registered pulse
//   o_overrun    one-cycle flag: edge ignored during an active pulse
//   o_any        OR of o_pulse
//
// Handshake: none. Every input is a level that is sampled on each clock.
// Each output is a plain registered strobe with no back-pressure.
//
// Per-channel FSM state is visible as g_ch[n].r_state (IDLE/ACTIVE).

module multi_pulse_gen #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [CH-1:0]    i_level,
  input  logic [1:0]       i_edge_mode,
  input  logic [LEN_W-1:0] i_pulse_len,
  input  logic             i_retrig,
  output logic [CH-1:0]    o_pulse,
  output logic [CH-1:0]    o_overrun,
  output logic             o_any
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  // The counter is loaded with L_eff-1. A pulse then stays high for
  // exactly L_eff cycles, including the cycle in which the load occurs.
  logic [LEN_W-1:0] w_len_m1;
  assign w_len_m1 = (i_pulse_len == '0) ? '0 : (i_pulse_len - LEN_W'(1));

  logic [CH-1:0] w_pulse;
  logic [CH-1:0] w_overrun;

  genvar n;
  for (n = 0; n < CH; n++) begin : g_ch
    logic             w_s;
    logic             r_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_edge;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;
    logic             r_overrun;
    logic             w_overrun_nxt;

    if (SYNC_STAGES == 0) begin : g_raw
      assign w_s = i_level[n];
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_level[n];
          for (int k = 1; k < SYNC_STAGES; k++) begin
            r_sync[k] <= r_sync[k-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end

    // r_prev resets to 0. A level that is already high at reset release
    // therefore appears as a rising edge.
    always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
        r_prev <= 1'b0;
      end else begin
        r_prev <= w_s;
      end
    end

    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    always_comb begin
      w_edge = 1'b0;
      case (i_edge_mode)
        2'b00:   w_edge = w_rise;
        2'b01:   w_edge = w_fall;
        2'b10:   w_edge = w_rise | w_fall;
        default: w_edge = 1'b0;
      endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_pulse   <= 1'b0;
        r_overrun <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_pulse   <= w_pulse_nxt;
        r_overrun <= w_overrun_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_pulse_nxt   = 1'b0;
      w_overrun_nxt = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = w_len_m1;
            w_pulse_nxt = 1'b1;
          end
        end
        S_ACTIVE: begin
          w_pulse_nxt = 1'b1;
          if (w_edge && i_retrig) begin
            w_cnt_nxt = w_len_m1;
          end else begin
            // An ignored edge is only flagged. The pulse keeps its
            // original timing, even when this is its last cycle.
            w_overrun_nxt = w_edge;
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - LEN_W'(1);
            end else begin
              w_state_nxt = S_IDLE;
              w_pulse_nxt = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end

    assign w_pulse[n]   = r_pulse;
    assign w_overrun[n] = r_overrun;
  end

  assign o_pulse   = w_pulse;
  assign o_overrun = w_overrun;
  assign o_any     = |w_pulse;

endmodule
